// File: rtl/hpdcache_cmo_front.sv
// +--------------------------------------------------------------------------+
// | hpdcache_cmo_front : single-outstanding CMO request front-end (rev 1.0)  |
// +--------------------------------------------------------------------------+
`default_nettype none

module hpdcache_cmo_front #(
  parameter int ADDR_W = 49,
  parameter int WORD_W = 64,
  parameter int ID_W   = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,

  input  logic              core_req_valid_i,
  output logic              core_req_ready_o,
  input  logic [2:0]        core_req_op_i,
  input  logic [ADDR_W-1:0] core_req_addr_i,
  input  logic [WORD_W-1:0] core_req_wdata_i,
  input  logic [ID_W-1:0]   core_req_sid_i,
  input  logic [ID_W-1:0]   core_req_tid_i,
  input  logic              core_req_need_rsp_i,

  output logic              cmoh_req_valid_o,
  input  logic              cmoh_req_ready_i,
  output logic [3:0]        cmoh_req_op_o,
  output logic [ADDR_W-1:0] cmoh_req_addr_o,
  output logic [WORD_W-1:0] cmoh_req_wdata_o,

  output logic              core_rsp_valid_o,
  input  logic              core_rsp_ready_i,
  output logic [ID_W-1:0]   core_rsp_sid_o,
  output logic [ID_W-1:0]   core_rsp_tid_o,
  output logic              core_rsp_error_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RSP   = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        op_q, op_dec;
  logic              need_rsp_q, error_q;
  logic [ADDR_W-1:0] addr_q;
  logic [WORD_W-1:0] wdata_q;
  logic [ID_W-1:0]   sid_q, tid_q;
  logic              accept, illegal;

  // Illegal encodings decode to all-zero so they can never reach the handler.
  always_comb begin
    op_dec = 4'b0000;
    case (core_req_op_i)
      3'd0:    op_dec = 4'b0001;
      3'd1:    op_dec = 4'b0010;
      3'd2:    op_dec = 4'b0100;
      3'd3:    op_dec = 4'b1000;
      default: op_dec = 4'b0000;
    endcase
  end

  assign illegal = core_req_op_i[2];
  assign accept  = core_req_valid_i && core_req_ready_o;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (!illegal)                 state_d = ISSUE;
          else if (core_req_need_rsp_i) state_d = RSP;
          else                          state_d = IDLE;
        end
      end
      ISSUE: if (cmoh_req_ready_i) state_d = WAIT;
      WAIT: begin
        if (cmoh_req_ready_i) state_d = need_rsp_q ? RSP : IDLE;
      end
      RSP:   if (core_rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      op_q       <= 4'b0000;
      need_rsp_q <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q       <= op_dec;
        need_rsp_q <= core_req_need_rsp_i;
        error_q    <= illegal;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      addr_q  <= core_req_addr_i;
      wdata_q <= core_req_wdata_i;
      sid_q   <= core_req_sid_i;
      tid_q   <= core_req_tid_i;
    end
  end

  assign core_req_ready_o = (state_q == IDLE);
  assign cmoh_req_valid_o = (state_q == ISSUE);
  assign cmoh_req_op_o    = (state_q == ISSUE) ? op_q : 4'b0000;
  assign cmoh_req_addr_o  = addr_q;
  assign cmoh_req_wdata_o = wdata_q;
  assign core_rsp_valid_o = (state_q == RSP);
  assign core_rsp_sid_o   = sid_q;
  assign core_rsp_tid_o   = tid_q;
  assign core_rsp_error_o = error_q;

endmodule

`default_nettype wire
